// File: rtl/seg7_pkg.sv
// Shared types and the hex segment table for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_controller.sv
// Scans a double-buffered 32-bit hex value across an 8-digit common-anode display.
//  state | meaning
//  BLANK | all anodes off between digit slots (anti-ghosting gap)
//  DRIVE | digit idx owns the segment lines
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic        blank_lz,
  output logic        frame_done,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int CNT_MAX = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  scan_state_t state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   disp_q, disp_d;
  logic [7:0]    dp_q, dp_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpo_q, dpo_d;
  logic          fd_q, fd_d;
  logic          boundary;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q      <= BLANK;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      disp_q       <= 32'h0;
      dp_q         <= 8'h0;
      pend_data_q  <= 32'h0;
      pend_dp_q    <= 8'h0;
      pend_valid_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dpo_q        <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      dp_q         <= dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dpo_q        <= dpo_d;
      fd_q         <= fd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    dp_d         = dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    boundary     = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d  = BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 3'd1;
          boundary = (idx_q == 3'd7);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase

    // Old pending applies at the boundary before a same-edge write replaces it.
    if (boundary && pend_valid_q) begin
      disp_d       = pend_data_q;
      dp_d         = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (wr_en) begin
      pend_data_d  = wr_data;
      pend_dp_d    = wr_dp;
      pend_valid_d = 1'b1;
    end

    fd_d = boundary;
  end

  // Outputs are decoded from next-state so they register on the entry edge.
  logic [31:0] disp_shift;
  logic [6:0]  dec_seg;
  logic        lz_blank;

  assign disp_shift = disp_d >> {idx_d, 2'b00};
  assign lz_blank   = blank_lz && (idx_d != 3'd0) && (disp_shift == 32'h0);

  seg7_hex_decoder u_dec (
    .nibble (disp_shift[3:0]),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dpo_d = 1'b1;
    if (state_d == DRIVE) begin
      an_d  = ~(8'h01 << idx_d);
      seg_d = lz_blank ? SEG_OFF : dec_seg;
      dpo_d = ~dp_d[idx_d];
    end
  end

  assign AN         = an_q;
  assign DP         = dpo_q;
  assign frame_done = fd_q;
  assign CA         = seg_q[0];
  assign CB         = seg_q[1];
  assign CC         = seg_q[2];
  assign CD         = seg_q[3];
  assign CE         = seg_q[4];
  assign CF         = seg_q[5];
  assign CG         = seg_q[6];

endmodule
